md_sequencer: RTL and testbench

Multi-cycle sequencer and HI/LO register owner for the extended ALU path (mult/multu/div/divu/mthi/mtlo). Sits beside the E-stage ALU: accepts an operation plus forwarded RS/RT operands when the instruction is in E, holds the result for a fixed latency, commits HI/LO, and raises a combinational stall toward D while any HI/LO-touching instruction would collide with an in-flight operation. mfhi/mflo read `hi`/`lo` directly; the W-stage XALUOUT value is taken from these outputs.

---
 rtl/md_sequencer.sv | 156 +++++++++++++++
 tb/tb_md_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle mult/div sequencer and HI/LO register owner
// Results are computed at accept time and held back until the busy window expires.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_in_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic        p_valid_q, p_valid_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;

  logic [63:0] smul, umul;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, sdiv_b, udiv_b;
  logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;
  logic        md_op;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign smul = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign umul = {32'd0, rs_val} * {32'd0, rt_val};

  assign a_neg    = rs_val[31];
  assign b_neg    = rt_val[31];
  assign div_zero = (rt_val == 32'd0);
  assign a_mag    = a_neg ? (~rs_val + 32'd1) : rs_val;
  assign b_mag    = b_neg ? (~rt_val + 32'd1) : rt_val;
  // A zero divisor is swapped for 1 so the dividers never see it; the result is discarded anyway.
  assign sdiv_b   = div_zero ? 32'd1 : b_mag;
  assign udiv_b   = div_zero ? 32'd1 : rt_val;
  assign sq_mag   = a_mag / sdiv_b;
  assign sr_mag   = a_mag % sdiv_b;
  assign sq       = (a_neg ^ b_neg) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr       = a_neg ? (~sr_mag + 32'd1) : sr_mag;
  assign uq       = rs_val / udiv_b;
  assign ur       = rs_val % udiv_b;

  assign md_op = start && (op >= OP_MULT) && (op <= OP_DIVU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    p_valid_d = p_valid_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              {p_hi_d, p_lo_d} = smul;
              p_valid_d = 1'b1;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = RUN;
              busy_d    = 1'b1;
            end
            OP_MULTU: begin
              {p_hi_d, p_lo_d} = umul;
              p_valid_d = 1'b1;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = RUN;
              busy_d    = 1'b1;
            end
            OP_DIV: begin
              p_hi_d    = sr;
              p_lo_d    = sq;
              p_valid_d = !div_zero;
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = RUN;
              busy_d    = 1'b1;
            end
            OP_DIVU: begin
              p_hi_d    = ur;
              p_lo_d    = uq;
              p_valid_d = !div_zero;
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = RUN;
              busy_d    = 1'b1;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          if (p_valid_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
          cnt_d     = 4'd0;
          p_valid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      p_hi_q    <= 32'd0;
      p_lo_q    <= 32'd0;
      p_valid_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      p_valid_q <= p_valid_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign stall = md_in_D && (busy_q || md_op);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - scoreboard bench for md_sequencer against an arithmetic reference model
module tb_md_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        md_in_D;
  logic        busy, stall;
  logic [31:0] hi, lo;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .md_in_D(md_in_D),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb[$];
  int          ncmp = 0;
  int          nfail = 0;
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int     ia, ib;
    longint p;
    ia = a;
    ib = b;
    p  = longint'(ia) * longint'(ib);
    if (sgn) return p;
    return 64'(a) * 64'(b);
  endfunction

  task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    int          ia, ib;
    longint      la, lb;
    logic [63:0] q64, r64;
    ia = a;
    ib = b;
    la = longint'(ia);
    lb = longint'(ib);
    if (sgn) begin
      q64 = la / lb;
      r64 = la % lb;
      q = q64[31:0];
      r = r64[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.hi = h; e.lo = l; e.len = n;
    return e;
  endfunction

  // Applies the architectural effect of the inputs sampled at this edge.
  task automatic model_update();
    logic [63:0] p;
    logic [31:0] q, r;
    if (m_left > 0) begin
      m_left--;
    end else if (start) begin
      case (op)
        3'd1, 3'd2: begin
          p = ref_mul(op == 3'd1, rs_val, rt_val);
          m_hi = p[63:32];
          m_lo = p[31:0];
          m_left = MC;
          sb.push_back(mk(m_hi, m_lo, MC));
        end
        3'd3, 3'd4: begin
          if (rt_val != 32'd0) begin
            ref_div(op == 3'd3, rs_val, rt_val, q, r);
            m_hi = r;
            m_lo = q;
          end
          m_left = DC;
          sb.push_back(mk(m_hi, m_lo, DC));
        end
        3'd5: begin m_hi = rs_val; sb.push_back(mk(m_hi, m_lo, 0)); end
        3'd6: begin m_lo = rs_val; sb.push_back(mk(m_hi, m_lo, 0)); end
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit st, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit md);
    start = st; op = o; rs_val = a; rt_val = b; md_in_D = md;
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask

  task automatic drain(input bit md);
    int guard;
    guard = 0;
    while (m_left > 0 && guard < 40) begin
      step(1'b0, 3'd0, 32'd0, 32'd0, md);
      guard++;
    end
    check("drain_timeout", 64'(m_left), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever a result becomes architecturally visible.
  initial begin
    bit   prev_busy, pend_mt, exp_stall;
    int   bcnt;
    exp_t e;
    prev_busy = 0; pend_mt = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 0; pend_mt = 0; bcnt = 0;
      end else begin
        exp_stall = md_in_D && (m_left > 0 || (start && op >= 3'd1 && op <= 3'd4));
        check("stall", 64'(stall), 64'(exp_stall));
        if (busy) bcnt++;
        if (pend_mt || (prev_busy && !busy)) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("commit_hi", 64'(hi), 64'(e.hi));
            check("commit_lo", 64'(lo), 64'(e.lo));
            check("busy_len", 64'(bcnt), 64'(e.len));
          end
          bcnt = 0;
        end
        pend_mt   = start && !busy && (op == 3'd5 || op == 3'd6);
        prev_busy = busy;
      end
    end
  end

  initial begin
    logic [31:0] specials [6];
    logic [31:0] a, b;
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};

    reset = 1'b0; start = 1'b1; op = 3'd1; rs_val = 32'd5; rt_val = 32'd7; md_in_D = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall_comb", 64'(stall), 64'd1);
    start = 1'b0;
    #1;
    check("rst_stall_idle", 64'(stall), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    step(1'b1, 3'd1, 32'hFFFFFFFE, 32'h3, 1'b1);
    drain(1'b1);
    check("mult_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo), 64'hFFFFFFFA);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    step(1'b1, 3'd2, 32'hFFFFFFFE, 32'h3, 1'b0);
    drain(1'b0);
    check("multu_hi", 64'(hi), 64'h00000002);
    check("multu_lo", 64'(lo), 64'hFFFFFFFA);

    step(1'b1, 3'd3, 32'hFFFFFFF9, 32'h2, 1'b0);
    drain(1'b0);
    check("div_hi", 64'(hi), 64'hFFFFFFFF);
    check("div_lo", 64'(lo), 64'hFFFFFFFD);

    step(1'b1, 3'd4, 32'h7, 32'h0, 1'b1);
    drain(1'b1);
    check("divu0_hi", 64'(hi), 64'hFFFFFFFF);
    check("divu0_lo", 64'(lo), 64'hFFFFFFFD);

    step(1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    drain(1'b0);
    check("divovf_hi", 64'(hi), 64'h0);
    check("divovf_lo", 64'(lo), 64'h80000000);

    step(1'b1, 3'd5, 32'h12345678, 32'h0, 1'b0);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_busy", 64'(busy), 64'd0);

    step(1'b1, 3'd4, 32'd100, 32'd7, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 3'd1, 32'h11111111, 32'h3, 1'b1);
    drain(1'b0);
    check("ign_hi", 64'(hi), 64'd2);
    check("ign_lo", 64'(lo), 64'd14);
    step(1'b1, 3'd2, 32'h10000, 32'h10000, 1'b0);
    check("b2b_busy", 64'(busy), 64'd1);
    drain(1'b0);
    check("b2b_hi", 64'(hi), 64'd1);
    check("b2b_lo", 64'(lo), 64'd0);

    step(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    sb.delete();
    m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    repeat (12) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    check("postrst_hi", 64'(hi), 64'd0);
    check("postrst_lo", 64'(lo), 64'd0);
    check("postrst_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), a, b, $urandom_range(0, 1) == 1);
    end
    drain(1'b0);
    repeat (2) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    check("final_hi", 64'(hi), 64'(m_hi));
    check("final_lo", 64'(lo), 64'(m_lo));
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
